// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider producing quotient and remainder of
//   in1 / in2. It uses the same start/finish handshake as the shift-add
//   multiplier and feeds the modular-reduction step of the RSA datapath.
//
//   Handshake: start is sampled only in IDLE (busy==0). The accepting edge
//   latches in1/in2. finish is a one-cycle pulse; quot/rem/div_by_zero are
//   valid while it is high, and quot/rem then hold until the next
//   completion. A new start may be issued during the finish cycle.
//
//   Build option: define EARLY_EXIT_EN to skip the iteration loop when
//   in1 < in2. This makes timing data-dependent. The default build has
//   constant latency for every non-zero divisor.
//
// Parameters
//   W_DIVIDEND  dividend/quotient width and iteration count
//   W_DIVISOR   divisor/remainder width (must be <= W_DIVIDEND)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only while idle
//   in1          dividend
//   in2          divisor
//   quot         registered quotient
//   rem          registered remainder
//   finish       one-cycle completion pulse
//   busy         high while iterating
//   div_by_zero  high together with finish when in2 was 0
//   dbg_state_o  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int W_DIVIDEND = 16,
  parameter int W_DIVISOR  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_DIVIDEND-1:0] in1,
  input  logic [W_DIVISOR-1:0]  in2,
  output logic [W_DIVIDEND-1:0] quot,
  output logic [W_DIVISOR-1:0]  rem,
  output logic                  finish,
  output logic                  busy,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(W_DIVIDEND + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ZERO  = 2'd2,
    S_SHORT = 2'd3   // early-exit completion, reachable only with EARLY_EXIT_EN
  } state_t;

  state_t                  state_q;
  logic [W_DIVIDEND-1:0]   dvd_q;   // dividend bits still to consume; quotient bits shift in at LSB
  logic [W_DIVISOR-1:0]    dvs_q;
  logic [W_DIVISOR-1:0]    p_q;     // partial remainder, always < divisor between steps
  logic [CW-1:0]           cnt_q;
  logic [W_DIVIDEND-1:0]   quot_q;
  logic [W_DIVISOR-1:0]    rem_q;
  logic                    finish_q;
  logic                    busy_q;
  logic                    dbz_q;

  // One restoring step. The shifted partial remainder needs W_DIVISOR+1
  // bits. After a conditional subtract it is again below the divisor, so
  // only W_DIVISOR bits are kept.
  logic [W_DIVISOR:0]      p_shift;
  logic                    q_bit;
  logic [W_DIVISOR-1:0]    p_d;
  logic [W_DIVIDEND-1:0]   dvd_d;

  always_comb begin
    p_shift = {p_q, dvd_q[W_DIVIDEND-1]};
    q_bit   = (p_shift >= {1'b0, dvs_q});
    p_d     = p_shift[W_DIVISOR-1:0];
    if (q_bit) begin
      p_d = W_DIVISOR'(p_shift - {1'b0, dvs_q});
    end
    dvd_d   = {dvd_q[W_DIVIDEND-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dvd_q <= in1;
            dvs_q <= in2;
            p_q   <= '0;
            cnt_q <= CW'(W_DIVIDEND);
            dbz_q <= 1'b0;
            if (in2 == '0) begin
              state_q <= S_ZERO;
`ifdef EARLY_EXIT_EN
            end else if (in1 < {{(W_DIVIDEND-W_DIVISOR){1'b0}}, in2}) begin
              state_q <= S_SHORT;
`endif
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          dvd_q <= dvd_d;
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_q   <= dvd_d;
            rem_q    <= p_d;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_ZERO: begin
          quot_q   <= '1;
          rem_q    <= dvd_q[W_DIVISOR-1:0];
          dbz_q    <= 1'b1;
          finish_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_SHORT: begin
          // in1 < in2, so the dividend itself fits the remainder width.
          quot_q   <= '0;
          rem_q    <= dvd_q[W_DIVISOR-1:0];
          finish_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign finish      = finish_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed bench for seq_divider. Expected quotients, remainders and
//   latencies are computed by hand from the operands.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] in1 = '0;
  logic [7:0]  in2 = '0;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        finish;
  logic        busy;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 16;
`endif

  seq_divider #(.W_DIVIDEND(16), .W_DIVISOR(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in1         (in1),
    .in2         (in2),
    .quot        (quot),
    .rem         (rem),
    .finish      (finish),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for finish. Returns the number of
  // edges from the accepting edge to the edge that raised finish, the number
  // of sampled cycles with busy high, and div_by_zero just after acceptance.
  // If poke is set, a start with in1=50/in2=5 is pulsed into edge E0+4.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit poke,
                        output int lat, output int busy_cyc, output logic dbz0);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dbz0     = div_by_zero;
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (finish) break;
      if (busy) busy_cyc++;
      if (poke && lat == 3) begin
        start = 1'b1;
        in1   = 16'd50;
        in2   = 8'd5;
      end
    end
  endtask

  int   lat;
  int   bcyc;
  logic dbz0;
  bit   seen;

  initial begin
    // reset state
    #23;
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 408 / 12
    run_op(16'd408, 8'd12, 1'b0, lat, bcyc, dbz0);
    check("t1_lat", lat, 16);
    check("t1_quot", quot, 34);
    check("t1_rem", rem, 0);
    check("t1_dbz", div_by_zero, 0);
    check("t1_busy_fin", busy, 0);
    @(posedge clk);
    #1;
    check("t1_finish_width", finish, 0);
    check("t1_quot_hold", quot, 34);

    // 2: 1000 / 7
    run_op(16'd1000, 8'd7, 1'b0, lat, bcyc, dbz0);
    check("t2_lat", lat, 16);
    check("t2_busy_cycles", bcyc, 16);
    check("t2_quot", quot, 142);
    check("t2_rem", rem, 6);
    check("t2_busy_fin", busy, 0);

    // 3: max operands, then back-to-back start in the finish cycle
    run_op(16'hFFFF, 8'hFF, 1'b0, lat, bcyc, dbz0);
    check("t3_lat", lat, 16);
    check("t3_quot", quot, 257);
    check("t3_rem", rem, 0);
    run_op(16'd100, 8'd10, 1'b0, lat, bcyc, dbz0);
    check("t3b_lat", lat, 16);
    check("t3b_quot", quot, 10);
    check("t3b_rem", rem, 0);

    // 4: divide by zero
    @(posedge clk);
    run_op(16'h1234, 8'd0, 1'b0, lat, bcyc, dbz0);
    check("t4_lat", lat, 1);
    check("t4_busy_cycles", bcyc, 0);
    check("t4_dbz", div_by_zero, 1);
    check("t4_quot", quot, 16'hFFFF);
    check("t4_rem", rem, 8'h34);

    // 5: dividend below divisor; div_by_zero clears on acceptance
    run_op(16'd5, 8'd9, 1'b0, lat, bcyc, dbz0);
    check("t5_dbz_clear", dbz0, 0);
    check("t5_lat", lat, SMALL_LAT);
    check("t5_quot", quot, 0);
    check("t5_rem", rem, 5);
    check("t5_dbz", div_by_zero, 0);

    // 6a: start while busy is ignored
    run_op(16'd1000, 8'd7, 1'b1, lat, bcyc, dbz0);
    check("t6a_lat", lat, 16);
    check("t6a_quot", quot, 142);
    check("t6a_rem", rem, 6);

    // 6b: reset mid-calculation aborts without a finish pulse
    @(negedge clk);
    start = 1'b1;
    in1   = 16'd1000;
    in2   = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("t6b_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6b_quot", quot, 0);
    check("t6b_rem", rem, 0);
    check("t6b_finish", finish, 0);
    check("t6b_busy", busy, 0);
    check("t6b_dbz", div_by_zero, 0);
    check("t6b_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (finish) seen = 1'b1;
    end
    check("t6b_no_finish", seen, 0);

    // recovery after reset
    run_op(16'd408, 8'd12, 1'b0, lat, bcyc, dbz0);
    check("t7_lat", lat, 16);
    check("t7_quot", quot, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
